// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor. Adds CHUNK bits of the two
// WIDTH-bit operands per clock through a ripple full-add cell, carrying
// between chunks in a register, with a start/busy/done handshake.
// Optional build macro: SEQ_ADDSUB_SAT_EN. When it is defined, s saturates
// on signed overflow. When it is not defined, s wraps modulo 2^WIDTH.
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             Cin,
    output logic [WIDTH-1:0] s,
    output logic             Cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0]       S_IDLE = 2'd0;
    localparam logic [1:0]       S_RUN  = 2'd1;
    localparam logic [1:0]       S_DONE = 2'd2;
    localparam logic [CW-1:0]    LAST   = CW'(N - 1);
    localparam logic [WIDTH-1:0] MASK   = WIDTH'({CHUNK{1'b1}});

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shadow;

    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_sum;
    logic [CHUNK:0]   w_c;
    logic [WIDTH-1:0] w_sh_next;
    logic [WIDTH-1:0] w_res;
    logic             w_last;
    logic             w_ovf;

    // Select the chunk being processed this cycle.
    always_comb begin
        w_base    = 32'(r_cnt) * 32'(CHUNK);
        w_a_chunk = CHUNK'(r_a >> w_base);
        w_b_chunk = CHUNK'(r_b >> w_base);
    end

    // Ripple chain of full-add cells across one chunk.
    assign w_c[0] = r_carry;
    for (genvar g = 0; g < CHUNK; g++) begin : g_fa
        assign w_sum[g]   = w_a_chunk[g] ^ w_b_chunk[g] ^ w_c[g];
        assign w_c[g+1]   = (w_a_chunk[g] & w_b_chunk[g]) |
                            (w_c[g] & (w_a_chunk[g] ^ w_b_chunk[g]));
    end

    // Merge this chunk's sum into the shadow result and form the final value.
    // The carry into bit CHUNK-1 of the last chunk is the carry into the MSB.
    always_comb begin
        w_sh_next = (r_shadow & ~(MASK << w_base)) | (WIDTH'(w_sum) << w_base);
        w_last    = (r_cnt == LAST);
        w_ovf     = w_c[CHUNK-1] ^ w_c[CHUNK];
`ifdef SEQ_ADDSUB_SAT_EN
        // Both effective operands share a sign on overflow, so r_a's MSB
        // selects the saturation direction.
        w_res = w_ovf ? {r_a[WIDTH-1], {(WIDTH-1){~r_a[WIDTH-1]}}} : w_sh_next;
`else
        w_res = w_sh_next;
`endif
    end

    // Control FSM plus datapath registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_shadow <= '0;
            s        <= '0;
            Cout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= x;
                        r_b     <= y ^ {WIDTH{sub}};
                        r_carry <= Cin ^ sub;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_shadow <= w_sh_next;
                    r_carry  <= w_c[CHUNK];
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        s        <= w_res;
                        Cout     <= w_c[CHUNK];
                        overflow <= w_ovf;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
